// File: rtl/text_unpack_ctrl.sv
// rtl/text_unpack_ctrl.sv - unpacks MSB-first 7-bit codes from a byte stream and emits mapped 8-bit characters
module text_unpack_ctrl #(
   parameter int MAX_LEN = 255,
   parameter int LW      = $clog2(MAX_LEN + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          FRAME_START,
   input  logic [LW-1:0] LEN,
   input  logic [7:0]    IN_BYTE,
   input  logic          IN_VALID,
   output logic          IN_READY,
   output logic [7:0]    OUT_CHAR,
   output logic          OUT_VALID,
   input  logic          OUT_READY,
   output logic          OUT_LAST,
   output logic          BUSY
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state;
   // Valid bits are kept left-aligned: the oldest bit sits at acc[14], so the
   // next code is always acc[14:8] and the lowest (15 - cnt) bits are zero.
   logic [14:0]   acc;
   logic [3:0]    cnt;
   logic [LW-1:0] remaining;

   logic          run;
   logic          have_left;
   logic          in_fire;
   logic          load;
   logic          out_fire;
   logic          last_fire;
   logic [14:0]   acc_ins;

   // Fixed 7-to-8-bit decompression table; everything else is a +32 offset.
   function automatic logic [7:0] map_code(input logic [6:0] c);
      logic [7:0] r;
      case (c)
         7'd95:   r = 8'd162;
         7'd97:   r = 8'd163;
         7'd109:  r = 8'd165;
         7'd111:  r = 8'd169;
         7'd112:  r = 8'd174;
         7'd125:  r = 8'd176;
         default: r = {1'b0, c} + 8'd32;
      endcase
      return r;
   endfunction

   assign run       = (state == RUN);
   assign have_left = (remaining != '0);
   assign IN_READY  = run && (cnt < 4'd7) && have_left;
   assign in_fire   = IN_READY && IN_VALID;
   // Load and accept cannot coincide: one needs cnt >= 7, the other cnt < 7.
   assign load      = run && (cnt >= 4'd7) && have_left && (!OUT_VALID || OUT_READY);
   assign out_fire  = OUT_VALID && OUT_READY;
   assign last_fire = out_fire && OUT_LAST;
   assign BUSY      = run;

   // New byte lands directly below the cnt bits already held.
   assign acc_ins   = {7'd0, IN_BYTE} << (4'd7 - cnt);

   // Frame sequencing: start on a non-empty FRAME_START, stop after the last handoff.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
      end else if (!run) begin
         if (FRAME_START && (LEN != '0)) begin
            state <= RUN;
         end
      end else if (last_fire) begin
         state <= IDLE;
      end
   end

   // Bit accumulator, bit count and remaining-character counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc       <= '0;
         cnt       <= '0;
         remaining <= '0;
      end else if (!run) begin
         if (FRAME_START && (LEN != '0)) begin
            acc       <= '0;
            cnt       <= '0;
            remaining <= LEN;
         end
      end else if (in_fire) begin
         acc <= acc | acc_ins;
         cnt <= cnt + 4'd8;
      end else if (load) begin
         acc       <= acc << 7;
         cnt       <= cnt - 4'd7;
         remaining <= remaining - LW'(1);
      end
   end

   // Output register: reload on load, clear valid on a plain handoff, otherwise hold.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OUT_CHAR  <= '0;
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
      end else if (load) begin
         OUT_CHAR  <= map_code(acc[14:8]);
         OUT_VALID <= 1'b1;
         OUT_LAST  <= (remaining == LW'(1));
      end else if (out_fire) begin
         OUT_VALID <= 1'b0;
         OUT_LAST  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_text_unpack_ctrl.sv
// tb/tb_text_unpack_ctrl.sv - randomized and directed self-checking bench for text_unpack_ctrl
module tb_text_unpack_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       FRAME_START;
   logic [7:0] LEN;
   logic [7:0] IN_BYTE;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] OUT_CHAR;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic       OUT_LAST;
   logic       BUSY;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] fb[$];

   text_unpack_ctrl dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .FRAME_START (FRAME_START),
      .LEN         (LEN),
      .IN_BYTE     (IN_BYTE),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .OUT_CHAR    (OUT_CHAR),
      .OUT_VALID   (OUT_VALID),
      .OUT_READY   (OUT_READY),
      .OUT_LAST    (OUT_LAST),
      .BUSY        (BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_map(input int c);
      case (c)
         95:      return 8'hA2;
         97:      return 8'hA3;
         109:     return 8'hA5;
         111:     return 8'hA9;
         112:     return 8'hAE;
         125:     return 8'hB0;
         default: return 8'(c + 32);
      endcase
   endfunction

   // in_mode: 0 = IN_VALID continuous, 1 = random gaps
   // out_mode: 0 = OUT_READY high, 1 = random, 2 = low for the first 5 valid cycles
   task automatic run_frame(input int len, input int in_mode, input int out_mode, input bit spurious);
      int         nb;
      int         bi;
      int         oi;
      int         iter;
      int         first_valid;
      int         hold;
      bit         done;
      bit         prev_stall;
      logic [7:0] prev_char;
      logic       prev_last;
      bit         bits[$];
      logic [7:0] exp_chars[$];
      nb = (7 * len + 7) / 8;
      foreach (fb[i]) for (int b = 7; b >= 0; b--) bits.push_back(fb[i][b]);
      for (int k = 0; k < len; k++) begin
         int code;
         code = 0;
         for (int j = 0; j < 7; j++) code = code * 2 + int'(bits[7 * k + j]);
         exp_chars.push_back(ref_map(code));
      end
      bi = 0; oi = 0; iter = 0; first_valid = -1; hold = 5;
      done = 0; prev_stall = 0; prev_char = '0; prev_last = 0;

      @(negedge CLK);
      FRAME_START = 1'b1;
      LEN         = 8'(len);
      IN_VALID    = 1'b0;
      OUT_READY   = 1'b0;
      while (!done && iter < 3000) begin
         @(negedge CLK);
         iter++;
         FRAME_START = spurious && ($urandom_range(0, 5) == 0);
         LEN         = 8'($urandom_range(0, 255));
         if (prev_stall) begin
            check("hold_valid", OUT_VALID, 1);
            check("hold_char", OUT_CHAR, prev_char);
            check("hold_last", OUT_LAST, prev_last);
         end
         if (OUT_VALID && first_valid < 0) first_valid = iter;
         IN_VALID = (bi < nb) && (in_mode == 0 || $urandom_range(0, 2) != 0);
         IN_BYTE  = IN_VALID ? fb[bi] : 8'($urandom);
         case (out_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = ($urandom_range(0, 2) != 0);
            default: begin
               if (OUT_VALID && hold > 0) begin
                  if (hold <= 4) check("bp_in_ready", IN_READY, 0);
                  OUT_READY = 1'b0;
                  hold--;
               end else begin
                  OUT_READY = 1'b1;
               end
            end
         endcase
         check("busy_run", BUSY, 1);
         if (bi == nb) check("no_extra_req", IN_READY, 0);
         if (IN_READY && IN_VALID) bi++;
         if (OUT_VALID && OUT_READY) begin
            check("out_char", OUT_CHAR, exp_chars[oi]);
            check("out_last", OUT_LAST, (oi == len - 1));
            oi++;
            if (oi == len) done = 1;
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_char  = OUT_CHAR;
         prev_last  = OUT_LAST;
      end
      if (!done) check("timeout_chars", oi, len);
      @(negedge CLK);
      FRAME_START = 1'b0;
      IN_VALID    = 1'b0;
      check("end_busy", BUSY, 0);
      check("end_valid", OUT_VALID, 0);
      check("end_in_ready", IN_READY, 0);
      check("byte_count", bi, nb);
      if (in_mode == 0) check("latency", first_valid, 3);
   endtask

   task automatic one_byte(input int len, input logic [7:0] b0);
      fb.delete();
      fb.push_back(b0);
      run_frame(len, 0, 0, 0);
   endtask

   initial begin
      logic [7:0] specials[6];
      RESET = 1'b1; FRAME_START = 1'b0; LEN = '0; IN_BYTE = '0;
      IN_VALID = 1'b0; OUT_READY = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_in_ready", IN_READY, 0);
      check("rst_valid", OUT_VALID, 0);
      check("rst_last", OUT_LAST, 0);
      check("rst_char", OUT_CHAR, 0);
      check("rst_busy", BUSY, 0);
      RESET = 1'b0;

      // Single character 'A'
      one_byte(1, 8'h42);

      // Special mappings
      specials = '{8'hBE, 8'hC2, 8'hDA, 8'hDE, 8'hE0, 8'hFA};
      foreach (specials[i]) one_byte(1, specials[i]);

      // "Hi" with padding, then the same frame under backpressure
      fb.delete(); fb.push_back(8'h51); fb.push_back(8'h24);
      run_frame(2, 0, 0, 0);
      run_frame(2, 0, 2, 0);

      // Seven zero bytes -> eight spaces
      fb.delete();
      repeat (7) fb.push_back(8'h00);
      run_frame(8, 0, 0, 0);

      // Reset mid-frame after one of two bytes
      @(negedge CLK);
      FRAME_START = 1'b1; LEN = 8'd2;
      @(negedge CLK);
      FRAME_START = 1'b0; IN_VALID = 1'b1; IN_BYTE = 8'h51; OUT_READY = 1'b1;
      check("mid_in_ready", IN_READY, 1);
      @(negedge CLK);
      IN_VALID = 1'b0; RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check("mid_rst_in_ready", IN_READY, 0);
      check("mid_rst_valid", OUT_VALID, 0);
      check("mid_rst_last", OUT_LAST, 0);
      check("mid_rst_char", OUT_CHAR, 0);
      check("mid_rst_busy", BUSY, 0);
      one_byte(1, 8'h42);

      // LEN = 0 start is ignored
      @(negedge CLK);
      FRAME_START = 1'b1; LEN = 8'd0;
      @(negedge CLK);
      FRAME_START = 1'b0; IN_VALID = 1'b1; IN_BYTE = 8'h42;
      check("len0_busy", BUSY, 0);
      check("len0_in_ready", IN_READY, 0);
      @(negedge CLK);
      IN_VALID = 1'b0;
      check("len0_valid", OUT_VALID, 0);
      check("len0_busy2", BUSY, 0);

      // Random frames with spurious FRAME_START pulses and random flow control
      for (int f = 0; f < 40; f++) begin
         int len;
         len = $urandom_range(1, 24);
         fb.delete();
         for (int i = 0; i < (7 * len + 7) / 8; i++) fb.push_back(8'($urandom));
         run_frame(len, (f % 4 == 0) ? 0 : 1, (f % 4 == 0) ? 0 : 1, (f % 4 != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
